// File: rtl/serial_add.sv
// Bit-serial LSB-first adder with valid/ready handshakes; one result bit per clock.
// Optional carry-in port enabled by defining SERIAL_ADD_CIN_EN.

module half_add (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

module serial_add #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADD_CIN_EN
    input  logic             cin,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_a_q, shift_a_d;
    logic [WIDTH-1:0] shift_b_q, shift_b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic cin_load;
`ifdef SERIAL_ADD_CIN_EN
    assign cin_load = cin;
`else
    assign cin_load = 1'b0;
`endif

    // Full adder on the current LSBs: two half adders plus an OR for the carry.
    logic ha0_s, ha0_c, fa_sum, ha1_c, fa_carry;

    half_add u_ha0 (.x(shift_a_q[0]), .y(shift_b_q[0]), .s(ha0_s),  .c(ha0_c));
    half_add u_ha1 (.x(ha0_s),        .y(carry_q),      .s(fa_sum), .c(ha1_c));

    assign fa_carry = ha0_c | ha1_c;

    always_comb begin
        state_d     = state_q;
        shift_a_d   = shift_a_q;
        shift_b_d   = shift_b_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        carry_d     = carry_q;
        bit_cnt_d   = bit_cnt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    shift_a_d  = a;
                    shift_b_d  = b;
                    carry_d    = cin_load;
                    bit_cnt_d  = '0;
                    in_ready_d = 1'b0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                shift_a_d = shift_a_q >> 1;
                shift_b_d = shift_b_q >> 1;
                sum_d     = WIDTH'({fa_sum, sum_q} >> 1);
                carry_d   = fa_carry;
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (bit_cnt_q == LAST_BIT) begin
                    cout_d      = fa_carry;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                // in_valid is deliberately ignored until the result is taken.
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            shift_a_q   <= '0;
            shift_b_q   <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            carry_q     <= 1'b0;
            bit_cnt_q   <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_a_q   <= shift_a_d;
            shift_b_q   <= shift_b_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            carry_q     <= carry_d;
            bit_cnt_q   <= bit_cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_serial_add.sv
// Self-checking bench for serial_add: directed cases plus a randomized run
// checked against an arithmetic reference (a + b + cin).

module tb_serial_add;
    localparam int WIDTH = 8;
`ifdef SERIAL_ADD_CIN_EN
    localparam bit CIN_EN = 1'b1;
`else
    localparam bit CIN_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int last_acc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_add #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
`ifdef SERIAL_ADD_CIN_EN
        .cin       (cin_in),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: plain integer addition, truncated to WIDTH+1 bits.
    function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                             input logic c);
        longint unsigned t;
        t = longint'(x) + longint'(y);
        if (CIN_EN && c) t = t + 1;
        return t[WIDTH:0];
    endfunction

    task automatic do_txn(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb, input logic xc,
                          input int bp, input bit hold, input bit chk_gap);
        int               n;
        logic [WIDTH:0]   exp;
        logic [WIDTH-1:0] s0;
        logic             c0;

        n = 0;
        while (!in_ready && n < 2 * WIDTH + 10) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_idle", 64'(in_ready), 64'(1));
        if (!in_ready) return;

        a         = xa;
        b         = xb;
        cin_in    = xc;
        in_valid  = 1'b1;
        out_ready = (bp == 0);
        exp       = model(xa, xb, xc);
        if (chk_gap) chk("issue_gap", 64'(cyc - last_acc), 64'(WIDTH + 2));
        last_acc = cyc;

        @(negedge clk);
        if (!hold) in_valid = 1'b0;
        a      = WIDTH'($urandom);
        b      = WIDTH'($urandom);
        cin_in = 1'($urandom);

        n = 0;
        while (!out_valid && n < WIDTH + 5) begin
            @(negedge clk);
            n++;
        end
        chk("latency", 64'(n), 64'(WIDTH));
        if (!out_valid) return;
        chk("in_ready_done", 64'(in_ready), 64'(0));
        chk("sum", 64'(sum), 64'(exp[WIDTH-1:0]));
        chk("cout", 64'(cout), 64'(exp[WIDTH]));
        s0 = sum;
        c0 = cout;

        for (int i = 0; i < bp; i++) begin
            in_valid = 1'b1;
            a        = WIDTH'($urandom);
            b        = WIDTH'($urandom);
            @(negedge clk);
            chk("bp_valid", 64'(out_valid), 64'(1));
            chk("bp_sum", 64'(sum), 64'(s0));
            chk("bp_cout", 64'(cout), 64'(c0));
            chk("bp_in_ready", 64'(in_ready), 64'(0));
        end

        out_ready = 1'b1;
        @(negedge clk);
        chk("consumed", 64'(out_valid), 64'(0));
        chk("in_ready_back", 64'(in_ready), 64'(1));
        chk("sum_hold_idle", 64'({cout, sum}), 64'({c0, s0}));
        in_valid = hold;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin_in    = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_sum", 64'(sum), 64'(0));
        chk("rst_cout", 64'(cout), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        do_txn(WIDTH'(8'h5A), WIDTH'(8'h3C), 1'b0, 0, 1'b0, 1'b0);
        do_txn(WIDTH'(8'hFF), WIDTH'(8'h01), 1'b0, 0, 1'b0, 1'b0);
        do_txn(WIDTH'(8'hFF), WIDTH'(8'hFF), 1'b0, 0, 1'b0, 1'b0);
        do_txn(WIDTH'($urandom), WIDTH'($urandom), 1'b0, 5, 1'b0, 1'b0);

        // Reset after three bits: partial result discarded, no out_valid.
        a        = WIDTH'(8'hA7);
        b        = WIDTH'(8'h6D);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrun_no_valid", 64'(out_valid), 64'(0));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrun_in_ready", 64'(in_ready), 64'(1));
        chk("midrun_out_valid", 64'(out_valid), 64'(0));
        chk("midrun_sum", 64'(sum), 64'(0));
        chk("midrun_cout", 64'(cout), 64'(0));
        @(negedge clk);
        chk("midrun_still_quiet", 64'(out_valid), 64'(0));
        do_txn(WIDTH'(8'h12), WIDTH'(8'h34), 1'b0, 0, 1'b0, 1'b0);

        do_txn(WIDTH'(8'hFF), WIDTH'(8'h00), 1'b1, 0, 1'b0, 1'b0);

        for (int i = 0; i < 4; i++)
            do_txn(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 0, 1'b1, i > 0);
        in_valid = 1'b0;

        for (int i = 0; i < 200; i++)
            do_txn(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom),
                   int'($urandom_range(0, 3)), 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/serial_add.md
# serial_add

Bit-serial adder that accepts two WIDTH-bit operands over a valid/ready handshake and adds them LSB-first, one bit per clock. It uses a single carry flip-flop and a full-adder cell built from two `half_add` instances plus an OR. It sits directly downstream of `half_add` in the arithmetic chain. It is the area-minimal alternative to a parallel adder when throughput is not critical.

## Interface
- WIDTH, 8: operand and sum width in bits; legal range 1..32.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset; synchronous, active-high.
- in_valid  input  1  operands a/b presented.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out_valid  output  1  sum/cout hold a completed result.
- out_ready  input  1  consumer takes result.
- sum  output  WIDTH  result bits [WIDTH-1:0].
- cout  output  1  carry out of bit WIDTH-1.

## Operation
- FSM states: IDLE, RUN, DONE. Encoding is free.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: load a→shift_a, b→shift_b; carry←0 (or cin, see Configuration); bit_cnt←0; go RUN.
- RUN:
  - in_ready=0.
  - Each edge computes s=shift_a[0]^shift_b[0]^carry and carry←majority(shift_a[0],shift_b[0],carry), using two `half_add` instances plus an OR.
  - Shift shift_a and shift_b right by 1. Shift s into the sum register from the MSB side.
  - bit_cnt++. At the edge where bit_cnt==WIDTH-1, go DONE and register cout←new carry.
- DONE:
  - out_valid=1. sum and cout are stable.
  - On out_valid&&out_ready: go IDLE.
  - in_valid is ignored in DONE.
- Arithmetic: {cout,sum} = a + b (+cin), modulo 2^(WIDTH+1). No overflow flag.
- sum and cout keep the last result after returning to IDLE. Only reset or the next RUN modifies them. Contents are defined only while out_valid=1.
- Operand inputs are sampled only on the accept edge. Later changes to a/b have no effect.
- WIDTH=1: RUN lasts exactly one edge.

## Timing
- Reset values:
  - state=IDLE, in_ready=1, out_valid=0.
  - sum=0, cout=0, carry=0, bit_cnt=0.
- in_ready and out_valid are decoded from registered state. There is no combinational path from in_valid or out_ready.
- Latency:
  - Operands accepted at edge k; out_valid rises after edge k+WIDTH.
  - If out_ready is already high, the result is consumed at edge k+WIDTH+1. in_ready is then high in the following cycle.
  - Minimum issue interval is WIDTH+2 cycles.
- Backpressure: out_ready low holds DONE indefinitely, with sum/cout unchanged.
- Reset mid-operation (RUN or DONE): the next edge returns to reset values. The partial result is discarded and no out_valid pulse occurs.
- rst has priority over all handshakes in the same cycle.

## Configuration
- SERIAL_ADD_CIN_EN defined:
  - Adds input port `cin` (1 bit), sampled with a/b on the accept edge and loaded into carry.
  - {cout,sum}=a+b+cin.
- SERIAL_ADD_CIN_EN undefined:
  - No cin port; carry is loaded with 0.
  - Behaviour otherwise identical.

## Test plan
- WIDTH=8, a=0x5A, b=0x3C, out_ready=1: accept at edge k; out_valid high after edge k+8; sum=0x96, cout=0; in_ready high again 2 cycles later.
- WIDTH=8, a=0xFF, b=0x01: sum=0x00, cout=1. Then a=0xFF, b=0xFF: sum=0xFE, cout=1.
- Backpressure: out_ready=0 for 5 cycles after out_valid rises. out_valid stays 1, sum/cout stay constant, in_ready stays 0, and a new in_valid with changed a/b is ignored. out_ready=1 → IDLE next edge.
- Reset mid-RUN after 3 bits processed: out_valid never asserts; next cycle in_ready=1, sum=0, cout=0. The following add of 0x12+0x34 gives 0x46, cout 0.
- Back-to-back: in_valid held high with 4 random operand pairs. Each is accepted exactly once, every WIDTH+2 cycles, and each result matches a+b. A 200-iteration random run with a scoreboard shows zero mismatches.
- SERIAL_ADD_CIN_EN defined, a=0xFF, b=0x00, cin=1: sum=0x00, cout=1. WIDTH=1 build, a=1, b=1: sum=0, cout=1, out_valid after 1 edge.
